// File: rtl/avalon_rr_arbiter_if.sv
// Avalon-MM bus bundle shared by the arbiter's master-facing and slave-facing ports.
// "master" is the side that issues commands, "slave" the side that answers them.
interface avalon_rr_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              read;
    logic              write;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;
    logic              waitrequest;

    modport master (
        output read,
        output write,
        output address,
        output writedata,
        input  readdata,
        input  waitrequest
    );

    modport slave (
        input  read,
        input  write,
        input  address,
        input  writedata,
        output readdata,
        output waitrequest
    );
endinterface

// File: rtl/avalon_rr_arbiter.sv
// Two-master round-robin arbiter and transaction sequencer for an 8-bit
// Avalon-MM register slave. Each granted transfer is issued as a one-cycle
// read/write pulse, the slave's waitrequest is waited out, and the owning
// master gets a one-cycle completion (waitrequest low).
// Optional WAIT-state timeout: define AVALON_ARB_TIMEOUT_EN.
module avalon_rr_arbiter #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 8,
    parameter int MAX_WAIT = 15
) (
    input  logic                clk,
    input  logic                reset,
    avalon_rr_arbiter_if.slave  m0,
    avalon_rr_arbiter_if.slave  m1,
    avalon_rr_arbiter_if.master s,
    output logic                timeout_err
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t state;
    logic   last_grant;   // 0: master 0 granted last, 1: master 1 granted last
    logic   gnt_q;        // owner of the transfer in flight
    logic   rd_q;         // transfer in flight is a read

    logic              req0;
    logic              req1;
    logic              pick;
    logic              pick_rd;
    logic              pick_wr;
    logic [ADDR_W-1:0] pick_addr;
    logic [DATA_W-1:0] pick_wdata;

`ifdef AVALON_ARB_TIMEOUT_EN
    localparam int               CNT_W    = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

    logic [CNT_W-1:0] wait_cnt;
`else
    assign timeout_err = 1'b0;
`endif

    // Request detection and round-robin choice of the next owner
    always_comb begin
        req0       = m0.read | m0.write;
        req1       = m1.read | m1.write;
        pick       = (req0 & req1) ? ~last_grant : req1;
        pick_rd    = pick ? m1.read      : m0.read;
        pick_wr    = pick ? m1.write     : m0.write;
        pick_addr  = pick ? m1.address   : m0.address;
        pick_wdata = pick ? m1.writedata : m0.writedata;
    end

    // Transaction sequencer; every bus output is a register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            last_grant     <= 1'b1;
            gnt_q          <= 1'b0;
            rd_q           <= 1'b0;
            s.read         <= 1'b0;
            s.write        <= 1'b0;
            s.address      <= '0;
            s.writedata    <= '0;
            m0.waitrequest <= 1'b1;
            m1.waitrequest <= 1'b1;
            m0.readdata    <= '0;
            m1.readdata    <= '0;
`ifdef AVALON_ARB_TIMEOUT_EN
            wait_cnt       <= '0;
            timeout_err    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req0 | req1) begin
                        gnt_q       <= pick;
                        last_grant  <= pick;
                        rd_q        <= pick_rd;
                        // read wins when a master raises both commands
                        s.read      <= pick_rd;
                        s.write     <= pick_wr & ~pick_rd;
                        s.address   <= pick_addr;
                        s.writedata <= pick_wdata;
                        state       <= ISSUE;
                    end
                end

                ISSUE: begin
                    s.read  <= 1'b0;
                    s.write <= 1'b0;
`ifdef AVALON_ARB_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                    state   <= WAIT;
                end

                WAIT: begin
                    if (!s.waitrequest) begin
                        // captured read data lands directly in the owner's
                        // readdata register; writes leave it untouched
                        if (rd_q) begin
                            if (gnt_q) m1.readdata <= s.readdata;
                            else       m0.readdata <= s.readdata;
                        end
                        if (gnt_q) m1.waitrequest <= 1'b0;
                        else       m0.waitrequest <= 1'b0;
                        state <= DONE;
                    end
`ifdef AVALON_ARB_TIMEOUT_EN
                    else if (wait_cnt == CNT_LAST) begin
                        if (gnt_q) begin
                            m1.readdata    <= '1;
                            m1.waitrequest <= 1'b0;
                        end else begin
                            m0.readdata    <= '1;
                            m0.waitrequest <= 1'b0;
                        end
                        timeout_err <= 1'b1;
                        state       <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end

                DONE: begin
                    m0.waitrequest <= 1'b1;
                    m1.waitrequest <= 1'b1;
`ifdef AVALON_ARB_TIMEOUT_EN
                    timeout_err    <= 1'b0;
`endif
                    state          <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_avalon_rr_arbiter.sv
// Self-checking bench for avalon_rr_arbiter: transaction-level reference model
// feeding two scoreboards (slave-side issue order, master-side completions).
module tb_avalon_rr_arbiter;
    localparam int ADDR_W   = 8;
    localparam int DATA_W   = 8;
    localparam int MAX_WAIT = 15;

    typedef struct {
        int         master;
        bit         rd;
        bit         wr;
        logic [7:0] addr;
        logic [7:0] wdata;
        int         delay;
    } txn_t;

    typedef struct {
        int         master;
        int         cyc;
        logic [7:0] rdata;
        bit         tmo;
    } done_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic timeout_err;

    avalon_rr_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m0_bus ();
    avalon_rr_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m1_bus ();
    avalon_rr_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) s_bus ();

    avalon_rr_arbiter #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .m0(m0_bus),
        .m1(m1_bus),
        .s(s_bus),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    bit mon_en      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name, input string why);
        vectors++;
        miscompares++;
        $display("FAIL %s: %s", name, why);
    endtask

    // ---------------- reference model ----------------
    logic [7:0] mem_m [8];
    logic [7:0] rd_last [2];
    bit         last_grant_m = 1'b1;
    txn_t       issue_q [$];
    done_t      done_q [$];

    function automatic txn_t mk(input int m, input bit rd, input bit wr,
                                input int addr, input int wdata, input int delay);
        txn_t t;
        t.master = m;
        t.rd     = rd;
        t.wr     = wr;
        t.addr   = 8'(addr);
        t.wdata  = 8'(wdata);
        t.delay  = delay;
        return t;
    endfunction

    // Expected outcome of one granted transfer starting arbitration at 'start'
    function automatic int model_txn(input txn_t t, input int start);
        done_t d;
        bit    tmo;
        tmo = 1'b0;
`ifdef AVALON_ARB_TIMEOUT_EN
        tmo = (t.delay >= MAX_WAIT);
`endif
        if (t.wr && !t.rd) mem_m[t.addr[2:0]] = t.wdata;
        d.master = t.master;
        d.tmo    = tmo;
        if (tmo)       d.rdata = 8'hFF;
        else if (t.rd) d.rdata = mem_m[t.addr[2:0]];
        else           d.rdata = rd_last[t.master];
        d.cyc = tmo ? start + 2 + MAX_WAIT : start + 3 + t.delay;
        rd_last[t.master] = d.rdata;
        issue_q.push_back(t);
        done_q.push_back(d);
        return d.cyc;
    endfunction

    // ---------------- behavioural slave ----------------
    logic [7:0] mem_seed [8];
    logic [7:0] mem_s [8];
    logic [7:0] s_rdata_reg = 8'h00;
    bit         seeded      = 1'b0;
    int         wcnt        = 0;
    int         next_delay  = 3;
    bit         prev_pulse  = 1'b0;

    assign s_bus.waitrequest = (wcnt != 0);
    assign s_bus.readdata    = s_rdata_reg;

    always @(posedge clk) begin
        if (!seeded) begin
            for (int i = 0; i < 8; i++) mem_s[i] <= mem_seed[i];
            seeded <= 1'b1;
        end else begin
            if (s_bus.write === 1'b1) mem_s[s_bus.address[2:0]] <= s_bus.writedata;
            if (s_bus.read === 1'b1)  s_rdata_reg <= mem_s[s_bus.address[2:0]];
            if (s_bus.read === 1'b1 || s_bus.write === 1'b1) wcnt <= next_delay;
            else if (wcnt != 0)                              wcnt <= wcnt - 1;
        end
    end

    // Slave-side scoreboard: issued command must match the model's grant order
    always @(negedge clk) begin : slave_chk
        bit   pulse;
        txn_t t;
        if (mon_en) begin
            pulse = (s_bus.read === 1'b1) || (s_bus.write === 1'b1);
            if (pulse) begin
                check("issue_one_cycle", 32'(prev_pulse), 0);
                check("issue_rd_wr_exclusive", 32'(s_bus.read & s_bus.write), 0);
                if (issue_q.size() == 0) begin
                    fail("issue_unexpected", "slave command with no granted transfer pending");
                    next_delay = 3;
                end else begin
                    t = issue_q.pop_front();
                    check("issue_read", 32'(s_bus.read), 32'(t.rd));
                    check("issue_write", 32'(s_bus.write), 32'(t.wr & ~t.rd));
                    check("issue_address", 32'(s_bus.address), 32'(t.addr));
                    if (t.wr && !t.rd) check("issue_writedata", 32'(s_bus.writedata), 32'(t.wdata));
                    next_delay = t.delay;
                end
            end
            prev_pulse = pulse;
        end
    end

    // Master-side scoreboard: completions in order, on time, with right data
    always @(negedge clk) begin : monitor
        done_t      e;
        logic       w0;
        logic       w1;
        logic [7:0] rd;
        int         m;
        if (mon_en) begin
            w0 = m0_bus.waitrequest;
            w1 = m1_bus.waitrequest;
            if (w0 === 1'b0 && w1 === 1'b0) begin
                fail("done_both", "both masters released in the same cycle");
            end else if (w0 === 1'b0 || w1 === 1'b0) begin
                m  = (w0 === 1'b0) ? 0 : 1;
                rd = (m == 1) ? m1_bus.readdata : m0_bus.readdata;
                if (done_q.size() == 0) begin
                    fail("done_unexpected", "master released with no transfer expected");
                end else begin
                    e = done_q.pop_front();
                    check("done_master", m, e.master);
                    check("done_cycle", cyc, e.cyc);
                    check("done_readdata", 32'(rd), 32'(e.rdata));
                    check("done_timeout_err", 32'(timeout_err), 32'(e.tmo));
                end
            end else begin
                check("idle_timeout_err", 32'(timeout_err), 0);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drop_m0();
        m0_bus.read  = 1'b0;
        m0_bus.write = 1'b0;
    endtask

    task automatic drop_m1();
        m1_bus.read  = 1'b0;
        m1_bus.write = 1'b0;
    endtask

    // One arbitration round: enabled masters raise requests together and hold
    // them until their own completion is seen.
    task automatic run_round(input bit en0, input txn_t t0, input bit en1, input txn_t t1);
        int start;
        int t;
        int budget;
        bit p0;
        bit p1;
        t0.master = 0;
        t1.master = 1;
        @(negedge clk);
        start = cyc;
        if (en0) begin
            m0_bus.read      = t0.rd;
            m0_bus.write     = t0.wr;
            m0_bus.address   = t0.addr;
            m0_bus.writedata = t0.wdata;
        end
        if (en1) begin
            m1_bus.read      = t1.rd;
            m1_bus.write     = t1.wr;
            m1_bus.address   = t1.addr;
            m1_bus.writedata = t1.wdata;
        end
        if (en0 && en1) begin
            if (last_grant_m) begin
                t = model_txn(t0, start);
                t = model_txn(t1, t + 1);
                last_grant_m = 1'b1;
            end else begin
                t = model_txn(t1, start);
                t = model_txn(t0, t + 1);
                last_grant_m = 1'b0;
            end
        end else if (en0) begin
            t = model_txn(t0, start);
            last_grant_m = 1'b0;
        end else begin
            t = model_txn(t1, start);
            last_grant_m = 1'b1;
        end
        p0     = en0;
        p1     = en1;
        budget = 300;
        while ((p0 || p1) && budget > 0) begin
            @(negedge clk);
            budget--;
            if (p0 && m0_bus.waitrequest === 1'b0) begin
                p0 = 1'b0;
                drop_m0();
            end
            if (p1 && m1_bus.waitrequest === 1'b0) begin
                p1 = 1'b0;
                drop_m1();
            end
        end
        if (p0 || p1) begin
            fail("round_budget", "master still stalled after cycle budget");
            drop_m0();
            drop_m1();
        end
    endtask

    initial begin : main
        txn_t none;
        txn_t a;
        txn_t b;
        int   sel;
        int   k;

        none = mk(0, 0, 0, 0, 0, 0);
        m0_bus.read = 1'b0;  m0_bus.write = 1'b0;  m0_bus.address = '0;  m0_bus.writedata = '0;
        m1_bus.read = 1'b0;  m1_bus.write = 1'b0;  m1_bus.address = '0;  m1_bus.writedata = '0;
        for (int i = 0; i < 8; i++) begin
            mem_seed[i] = 8'($urandom);
            mem_m[i]    = mem_seed[i];
        end
        mem_seed[5] = 8'h12;
        mem_m[5]    = 8'h12;
        rd_last[0]  = 8'h00;
        rd_last[1]  = 8'h00;

        #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_m0_waitrequest", 32'(m0_bus.waitrequest), 1);
        check("rst_m1_waitrequest", 32'(m1_bus.waitrequest), 1);
        check("rst_s_read", 32'(s_bus.read), 0);
        check("rst_s_write", 32'(s_bus.write), 0);
        check("rst_s_address", 32'(s_bus.address), 0);
        check("rst_s_writedata", 32'(s_bus.writedata), 0);
        check("rst_m0_readdata", 32'(m0_bus.readdata), 0);
        check("rst_m1_readdata", 32'(m1_bus.readdata), 0);
        check("rst_timeout_err", 32'(timeout_err), 0);
        reset  = 1'b1;
        mon_en = 1'b1;

        // reset asserted while a read sits in WAIT: dropped with no completion
        @(negedge clk);
        a = mk(0, 1, 0, 2, 0, 3);
        m0_bus.read    = 1'b1;
        m0_bus.address = 8'd2;
        issue_q.push_back(a);
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("midwait_m0_waitrequest", 32'(m0_bus.waitrequest), 1);
        check("midwait_m1_waitrequest", 32'(m1_bus.waitrequest), 1);
        check("midwait_s_read", 32'(s_bus.read), 0);
        check("midwait_s_write", 32'(s_bus.write), 0);
        check("midwait_m0_readdata", 32'(m0_bus.readdata), 0);
        drop_m0();
        @(negedge clk);
        reset        = 1'b1;
        last_grant_m = 1'b1;
        rd_last[0]   = 8'h00;
        rd_last[1]   = 8'h00;
        done_q.delete();
        issue_q.delete();
        repeat (4) @(negedge clk);

        // single read of register 5
        run_round(1'b1, mk(0, 1, 0, 5, 0, 3), 1'b0, none);
        // m1 writes then reads back register 6
        run_round(1'b0, none, 1'b1, mk(1, 0, 1, 6, 8'hA5, 3));
        run_round(1'b0, none, 1'b1, mk(1, 1, 0, 6, 0, 3));
        // tied requests, twice
        run_round(1'b1, mk(0, 1, 0, 0, 0, 3), 1'b1, mk(1, 1, 0, 3, 0, 3));
        run_round(1'b1, mk(0, 1, 0, 4, 0, 3), 1'b1, mk(1, 1, 0, 2, 0, 3));
        // read and write together: only the read happens, register 1 intact
        run_round(1'b1, mk(0, 1, 1, 1, 8'h5A, 3), 1'b0, none);
        run_round(1'b1, mk(0, 1, 0, 1, 0, 3), 1'b0, none);

`ifdef AVALON_ARB_TIMEOUT_EN
        run_round(1'b1, mk(0, 1, 0, 0, 0, MAX_WAIT + 25), 1'b0, none);
        run_round(1'b0, none, 1'b1, mk(1, 1, 0, 5, 0, 3));
`endif

        // randomized rounds
        repeat (60) begin
            sel = $urandom_range(1, 3);
            k   = $urandom_range(0, 9);
            a   = mk(0, k < 4 || k == 9, k >= 4, $urandom_range(0, 6), $urandom, $urandom_range(0, 6));
            k   = $urandom_range(0, 9);
            b   = mk(1, k < 4 || k == 9, k >= 4, $urandom_range(0, 6), $urandom, $urandom_range(0, 6));
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_round(sel[0], a, sel[1], b);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drained", done_q.size() + issue_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit reached");
    end

endmodule
